// File: rtl/mem_access_unit.sv
// Load/store unit between the ALU and data memory. Accepts one access at a time from
// the EX stage, runs a single req/ack bus transaction, and returns extended load data.
// A transaction that sees no mem_ack within TIMEOUT_CYCLES busy cycles ends with an error.
// Optional build macro: MISALIGN_TRAP_EN. When defined, misaligned half/word accesses
// return an error without touching the bus. Otherwise the low address bits are truncated.
module mem_access_unit #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  rsp_valid,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_err,
  output logic                  stall,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [3:0]            mem_be,
  output logic [31:0]           mem_wdata,
  input  logic                  mem_ack,
  input  logic [31:0]           mem_rdata
);

  localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            we_q, uns_q;
  logic [1:0]      size_q, off_q;
  logic            mem_req_q, mem_we_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [3:0]      mem_be_q;
  logic [31:0]     mem_wdata_q;
  logic [31:0]     rsp_rdata_q;
  logic            rsp_err_q;

  logic            accept, illegal;
  logic [1:0]      off_new;
  logic [3:0]      be_new;
  logic [31:0]     wdata_new, lane, load_ext;

  assign accept = (state_q == StIdle) && req_valid;

  // Decode an incoming request: legality, effective lane offset, byte enables, store data.
  always_comb begin
    illegal   = 1'b0;
    off_new   = 2'b00;
    be_new    = 4'b0000;
    wdata_new = req_wdata;
    unique case (req_size)
      2'b00: begin
        off_new   = req_addr[1:0];
        be_new    = 4'b0001 << req_addr[1:0];
        wdata_new = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        off_new   = {req_addr[1], 1'b0};
        be_new    = 4'b0011 << {req_addr[1], 1'b0};
        wdata_new = {2{req_wdata[15:0]}};
      end
      2'b10: begin
        be_new = 4'b1111;
      end
      default: illegal = 1'b1;
    endcase
`ifdef MISALIGN_TRAP_EN
    if ((req_size == 2'b01) && req_addr[0]) illegal = 1'b1;
    if ((req_size == 2'b10) && (req_addr[1:0] != 2'b00)) illegal = 1'b1;
`endif
  end

  // Select the addressed lane of the returned word and sign/zero-extend it.
  always_comb begin
    lane     = mem_rdata >> {off_q, 3'b000};
    load_ext = lane;
    if (size_q == 2'b00) begin
      load_ext = uns_q ? {24'd0, lane[7:0]} : {{24{lane[7]}}, lane[7:0]};
    end else if (size_q == 2'b01) begin
      load_ext = uns_q ? {16'd0, lane[15:0]} : {{16{lane[15]}}, lane[15:0]};
    end
  end

  // Next-state logic and busy-cycle counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (req_valid) state_d = illegal ? StResp : StBusy;
      end
      StBusy: begin
        if (mem_ack || (cnt_q == CntLast)) state_d = StResp;
        else cnt_d = cnt_q + CntW'(1);
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State, captured request fields, bus outputs and response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      uns_q       <= 1'b0;
      size_q      <= 2'b00;
      off_q       <= 2'b00;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_be_q    <= 4'b0000;
      mem_wdata_q <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        we_q   <= req_we;
        uns_q  <= req_unsigned;
        size_q <= req_size;
        off_q  <= off_new;
        if (illegal) begin
          rsp_err_q   <= 1'b1;
          rsp_rdata_q <= '0;
        end else begin
          mem_req_q   <= 1'b1;
          mem_we_q    <= req_we;
          mem_addr_q  <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
          mem_be_q    <= be_new;
          mem_wdata_q <= wdata_new;
        end
      end else if ((state_q == StBusy) && (state_d == StResp)) begin
        mem_req_q <= 1'b0;
        // An ack in the final counted cycle still completes without error.
        if (mem_ack) begin
          rsp_err_q   <= 1'b0;
          rsp_rdata_q <= we_q ? 32'd0 : load_ext;
        end else begin
          rsp_err_q   <= 1'b1;
          rsp_rdata_q <= '0;
        end
      end
    end
  end

  assign req_ready = (state_q == StIdle);
  assign stall     = (state_q != StIdle);
  assign rsp_valid = (state_q == StResp);
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_be    = mem_be_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed scenarios plus randomized accesses
// compared against a byte-lane reference model. Honours MISALIGN_TRAP_EN like the design.
module tb_mem_access_unit;

  logic        clk, rst_n;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_err, stall;
  logic [31:0] rsp_rdata;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;

  int total = 0;
  int bad   = 0;

  mem_access_unit #(.ADDR_WIDTH(32), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .stall(stall), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic bit m_illegal(logic [1:0] size, logic [31:0] addr);
    if (size == 2'd3) return 1'b1;
`ifdef MISALIGN_TRAP_EN
    if (size == 2'd1 && addr[0]) return 1'b1;
    if (size == 2'd2 && addr[1:0] != 2'd0) return 1'b1;
`endif
    return 1'b0;
  endfunction

  function automatic int m_nbytes(logic [1:0] size);
    return 1 << size;
  endfunction

  function automatic int m_off(logic [1:0] size, logic [31:0] addr);
    int nb = m_nbytes(size);
    return ((addr % 4) / nb) * nb;
  endfunction

  function automatic logic [3:0] m_be(logic [1:0] size, logic [31:0] addr);
    int v = ((1 << m_nbytes(size)) - 1) << m_off(size, addr);
    return v[3:0];
  endfunction

  function automatic logic [31:0] m_wdata(logic [1:0] size, logic [31:0] wd);
    logic [31:0] r;
    int nb = m_nbytes(size);
    for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % nb) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] m_load(logic [1:0] size, logic uns, logic [31:0] addr,
                                         logic [31:0] rd);
    longint unsigned v, mask;
    int bits = 8 * m_nbytes(size);
    mask = (64'd1 << bits) - 64'd1;
    v = (longint'(rd) >> (8 * m_off(size, addr))) & mask;
    if (!uns && bits < 32 && v >= (64'd1 << (bits - 1))) v = v - (64'd1 << bits);
    return v[31:0];
  endfunction

  // ---------------- transaction driver (observes only, compares nothing) ----------------
  // ack_delay: number of mem_req cycles before the ack cycle; -1 means never ack.
  // lat: cycles from the accepting edge to the rsp_valid sample (-1 if rsp_valid never rises).
  task automatic run_txn(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wd, input int ack_delay,
                         input logic [31:0] rd, output int lat, output logic [31:0] o_rdata,
                         output logic o_err, output logic [31:0] o_maddr,
                         output logic [3:0] o_be, output logic [31:0] o_wdata,
                         output logic o_mwe, output int req_cycles);
    int n;
    lat = -1; o_rdata = 'x; o_err = 1'bx; o_maddr = 'x; o_be = 'x; o_wdata = 'x;
    o_mwe = 1'bx; req_cycles = 0;
    for (int w = 0; w < 20 && !req_ready; w++) begin
      @(posedge clk); #1;
    end
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0; req_we = 1'($urandom); req_size = 2'($urandom);
    req_unsigned = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
    n = 1;
    while (n < 100) begin
      if (rsp_valid) begin
        lat = n; o_rdata = rsp_rdata; o_err = rsp_err;
        break;
      end
      mem_ack = 1'b0; mem_rdata = $urandom;
      if (mem_req) begin
        req_cycles++;
        if (req_cycles == 1) begin
          o_maddr = mem_addr; o_be = mem_be; o_wdata = mem_wdata; o_mwe = mem_we;
        end
        if (ack_delay >= 0 && req_cycles == ack_delay + 1) begin
          mem_ack = 1'b1; mem_rdata = rd;
        end
      end
      @(posedge clk); #1;
      n++;
    end
    mem_ack = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
    req_addr = '0; req_wdata = '0; mem_ack = 1'b0; mem_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", req_ready); end
    total++; if ({rsp_valid, rsp_err, stall, mem_req, mem_we} !== 5'b0) begin
      bad++; $display("FAIL reset_ctrl got=%b exp=00000", {rsp_valid, rsp_err, stall, mem_req, mem_we});
    end
    total++; if ({rsp_rdata, mem_addr, mem_wdata, mem_be} !== 100'd0) begin
      bad++; $display("FAIL reset_data got=%h/%h/%h/%h exp=0", rsp_rdata, mem_addr, mem_wdata, mem_be);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_word_store();
    int lat, rc; logic [31:0] rdv, ma, mw; logic er, mwe; logic [3:0] be;
    run_txn(1'b1, 2'd2, 1'b0, 32'h100, 32'hDEADBEEF, 2, 32'h0, lat, rdv, er, ma, be, mw, mwe, rc);
    total++; if (be !== 4'b1111) begin bad++; $display("FAIL wst_be got=%b exp=1111", be); end
    total++; if (ma !== 32'h100) begin bad++; $display("FAIL wst_addr got=%h exp=100", ma); end
    total++; if (mw !== 32'hDEADBEEF || mwe !== 1'b1) begin
      bad++; $display("FAIL wst_wdata got=%h we=%b exp=deadbeef we=1", mw, mwe);
    end
    total++; if (lat !== 4) begin bad++; $display("FAIL wst_latency got=%0d exp=4", lat); end
    total++; if (er !== 1'b0 || rdv !== 32'd0) begin
      bad++; $display("FAIL wst_rsp got err=%b data=%h exp err=0 data=0", er, rdv);
    end
    @(posedge clk); #1;
    total++; if (rsp_valid !== 1'b0 || stall !== 1'b0) begin
      bad++; $display("FAIL wst_pulse got valid=%b stall=%b exp 0/0", rsp_valid, stall);
    end
  endtask

  task automatic test_byte_load();
    int lat, rc; logic [31:0] rdv, ma, mw; logic er, mwe; logic [3:0] be;
    run_txn(1'b0, 2'd0, 1'b0, 32'h103, 32'h0, 0, 32'h80FF0000, lat, rdv, er, ma, be, mw, mwe, rc);
    total++; if (rdv !== 32'hFFFFFF80 || er !== 1'b0 || lat !== 2) begin
      bad++; $display("FAIL bld_signed got=%h err=%b lat=%0d exp=ffffff80 0 2", rdv, er, lat);
    end
    total++; if (be !== 4'b1000 || ma !== 32'h100) begin
      bad++; $display("FAIL bld_bus got be=%b addr=%h exp be=1000 addr=100", be, ma);
    end
    run_txn(1'b0, 2'd0, 1'b1, 32'h103, 32'h0, 1, 32'h80FF0000, lat, rdv, er, ma, be, mw, mwe, rc);
    total++; if (rdv !== 32'h00000080 || er !== 1'b0) begin
      bad++; $display("FAIL bld_unsigned got=%h err=%b exp=00000080 0", rdv, er);
    end
  endtask

  task automatic test_half_store();
    int lat, rc; logic [31:0] rdv, ma, mw; logic er, mwe; logic [3:0] be;
    run_txn(1'b1, 2'd1, 1'b0, 32'h102, 32'h1234ABCD, 0, 32'h0, lat, rdv, er, ma, be, mw, mwe, rc);
    total++; if (be !== 4'b1100 || mw !== 32'hABCDABCD) begin
      bad++; $display("FAIL hst got be=%b wdata=%h exp be=1100 wdata=abcdabcd", be, mw);
    end
  endtask

  task automatic test_timeout();
    int lat, rc; logic [31:0] rdv, ma, mw; logic er, mwe; logic [3:0] be;
    run_txn(1'b0, 2'd2, 1'b0, 32'h40, 32'h0, -1, 32'h0, lat, rdv, er, ma, be, mw, mwe, rc);
    total++; if (rc !== 16) begin bad++; $display("FAIL tmo_req_cycles got=%0d exp=16", rc); end
    total++; if (lat !== 17 || er !== 1'b1 || rdv !== 32'd0) begin
      bad++; $display("FAIL tmo_rsp got lat=%0d err=%b data=%h exp 17 1 0", lat, er, rdv);
    end
    total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL tmo_mreq got=%b exp=0", mem_req); end
    @(posedge clk); #1;
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL tmo_stall got=%b exp=0", stall); end
    // Ack in the last counted cycle must win over the timeout.
    run_txn(1'b0, 2'd2, 1'b0, 32'h44, 32'h0, 15, 32'h5A5A1234, lat, rdv, er, ma, be, mw, mwe, rc);
    total++; if (lat !== 17 || er !== 1'b0 || rdv !== 32'h5A5A1234) begin
      bad++; $display("FAIL tmo_ack_wins got lat=%0d err=%b data=%h exp 17 0 5a5a1234", lat, er, rdv);
    end
  endtask

  task automatic test_reserved_size();
    int lat, rc; logic [31:0] rdv, ma, mw; logic er, mwe; logic [3:0] be;
    run_txn(1'b0, 2'd3, 1'b0, 32'h80, 32'h0, 0, 32'hFFFFFFFF, lat, rdv, er, ma, be, mw, mwe, rc);
    total++; if (lat !== 1 || er !== 1'b1 || rc !== 0 || rdv !== 32'd0) begin
      bad++; $display("FAIL rsvd got lat=%0d err=%b reqs=%0d data=%h exp 1 1 0 0", lat, er, rc, rdv);
    end
  endtask

  task automatic test_misalign();
    int lat, rc; logic [31:0] rdv, ma, mw; logic er, mwe; logic [3:0] be;
    run_txn(1'b0, 2'd2, 1'b0, 32'h101, 32'h0, 0, 32'hCAFEF00D, lat, rdv, er, ma, be, mw, mwe, rc);
`ifdef MISALIGN_TRAP_EN
    total++; if (lat !== 1 || er !== 1'b1 || rc !== 0) begin
      bad++; $display("FAIL misalign_trap got lat=%0d err=%b reqs=%0d exp 1 1 0", lat, er, rc);
    end
`else
    total++; if (ma !== 32'h100 || be !== 4'b1111 || rdv !== 32'hCAFEF00D || er !== 1'b0) begin
      bad++; $display("FAIL misalign_trunc got addr=%h be=%b data=%h err=%b exp 100 1111 cafef00d 0",
                      ma, be, rdv, er);
    end
`endif
  endtask

  task automatic test_reset_busy();
    int lat, rc; logic [31:0] rdv, ma, mw; logic er, mwe; logic [3:0] be;
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_addr = 32'h200;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    total++; if (mem_req !== 1'b0 || stall !== 1'b0) begin
      bad++; $display("FAIL rst_busy got mreq=%b stall=%b exp 0 0", mem_req, stall);
    end
    @(posedge clk); #1;
    rst_n = 1'b1; mem_ack = 1'b1; mem_rdata = 32'h12345678;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    total++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      bad++; $display("FAIL rst_late_ack got valid=%b ready=%b exp 0 1", rsp_valid, req_ready);
    end
    run_txn(1'b0, 2'd1, 1'b1, 32'h206, 32'h0, 1, 32'hBEEF0000, lat, rdv, er, ma, be, mw, mwe, rc);
    total++; if (rdv !== 32'h0000BEEF || er !== 1'b0 || lat !== 3) begin
      bad++; $display("FAIL rst_recover got data=%h err=%b lat=%0d exp 0000beef 0 3", rdv, er, lat);
    end
  endtask

  task automatic test_random();
    int lat, rc, dly; logic [31:0] rdv, ma, mw, addr, wd, rd; logic er, mwe, we, uns;
    logic [3:0] be; logic [1:0] size;
    for (int i = 0; i < 40; i++) begin
      we = 1'($urandom); uns = 1'($urandom); size = 2'($urandom_range(0, 3));
      addr = $urandom; wd = $urandom; rd = $urandom; dly = $urandom_range(0, 4);
      run_txn(we, size, uns, addr, wd, dly, rd, lat, rdv, er, ma, be, mw, mwe, rc);
      if (m_illegal(size, addr)) begin
        total++; if (lat !== 1 || er !== 1'b1 || rc !== 0 || rdv !== 32'd0) begin
          bad++; $display("FAIL rnd_illegal[%0d] got lat=%0d err=%b reqs=%0d data=%h exp 1 1 0 0",
                          i, lat, er, rc, rdv);
        end
      end else begin
        total++; if (lat !== dly + 2 || er !== 1'b0 || rc !== dly + 1) begin
          bad++; $display("FAIL rnd_timing[%0d] got lat=%0d err=%b reqs=%0d exp %0d 0 %0d",
                          i, lat, er, rc, dly + 2, dly + 1);
        end
        total++; if (ma !== {addr[31:2], 2'b00} || be !== m_be(size, addr) || mwe !== we) begin
          bad++; $display("FAIL rnd_bus[%0d] got addr=%h be=%b we=%b exp %h %b %b", i, ma, be, mwe,
                          {addr[31:2], 2'b00}, m_be(size, addr), we);
        end
        if (we) begin
          total++; if (mw !== m_wdata(size, wd) || rdv !== 32'd0) begin
            bad++; $display("FAIL rnd_store[%0d] got wdata=%h data=%h exp %h 0", i, mw, rdv,
                            m_wdata(size, wd));
          end
        end else begin
          total++; if (rdv !== m_load(size, uns, addr, rd)) begin
            bad++; $display("FAIL rnd_load[%0d] got=%h exp=%h", i, rdv, m_load(size, uns, addr, rd));
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_word_store();
    test_byte_load();
    test_half_store();
    test_timeout();
    test_reserved_size();
    test_misalign();
    test_reset_busy();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
